sys_bus_xbar: RTL and testbench

- Parametrised, registered successor to the 2x2 combinational system bus.
- Connects NUM_MASTERS masters (core LSU, fetch, DMA, debug) to NUM_SLAVES slaves through one shared transaction channel.
- Provides fixed-priority or round-robin arbitration, a req/ack handshake, address-window decode, an error response for unmapped addresses, and a slave timeout.
- Sits between the pipeline's memory ports and the RAM/peripheral slaves. It drives per-master hold_flag so the pipeline stalls while waiting.

---
 rtl/sys_bus_pkg.sv | 30 +++
 rtl/sys_bus_xbar_if.sv | 52 +++++
 rtl/sys_bus_arbiter.sv | 55 +++++
 rtl/sys_bus_xbar.sv | 222 ++++++++++++++++++++++
 tb/tb_sys_bus_xbar.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_pkg.sv
// ----------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for the system bus crossbar:
//   - state_t   : transaction FSM encoding (IDLE / BUSY / RESP)
//   - ARB_FIXED / ARB_RR : arbitration mode selectors
//   - clog2()   : ceiling log2 with a minimum result of 1
// No ports (package).
// ----------------------------------------------------------------------------
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index fields never collapse to zero bits, even for a single master.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sys_bus_xbar_if.sv
// ----------------------------------------------------------------------------
// sys_bus_xbar_if
// Bundles the master-side and slave-side signals of the system bus crossbar.
// Modports:
//   master : view of the requesting masters (drive m_req/m_we/m_adr/m_wdata,
//            receive m_rdata/m_ack/m_err/hold_flag)
//   slave  : view of the slaves (receive s_req/s_we/s_adr/s_wdata,
//            drive s_rdata/s_ack)
//   xbar   : view of the crossbar itself (inverse of both of the above)
// Per-master and per-slave buses are flattened, entry i at [i*W +: W].
// ----------------------------------------------------------------------------
interface sys_bus_xbar_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);

    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
    logic [NUM_MASTERS-1:0]        m_ack;
    logic [NUM_MASTERS-1:0]        m_err;
    logic [NUM_MASTERS-1:0]        hold_flag;

    logic [NUM_SLAVES-1:0]         s_req;
    logic                          s_we;
    logic [ADDR_W-1:0]             s_adr;
    logic [DATA_W-1:0]             s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0]  s_rdata;
    logic [NUM_SLAVES-1:0]         s_ack;

    modport master (
        output m_req, m_we, m_adr, m_wdata,
        input  m_rdata, m_ack, m_err, hold_flag
    );

    modport slave (
        input  s_req, s_we, s_adr, s_wdata,
        output s_rdata, s_ack
    );

    modport xbar (
        input  m_req, m_we, m_adr, m_wdata,
        output m_rdata, m_ack, m_err, hold_flag,
        output s_req, s_we, s_adr, s_wdata,
        input  s_rdata, s_ack
    );

endinterface

// File: rtl/sys_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sys_bus_arbiter
// Purely combinational request arbiter.
//   ARB_FIXED : lowest requesting index wins.
//   ARB_RR    : search starts one past i_rr_ptr, wrapping modulo NUM_MASTERS.
// Ports:
//   i_req    [NUM_MASTERS]  request vector
//   i_rr_ptr [IDX_W]        last granted index (round-robin mode only)
//   o_grant  [NUM_MASTERS]  one-hot grant
//   o_idx    [IDX_W]        binary index of the grant
//   o_valid                 at least one request present
// ----------------------------------------------------------------------------
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int  NUM_MASTERS = 2,
    parameter int  ARB_MODE    = ARB_FIXED,
    localparam int IDX_W       = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_valid
);

    int w_start;
    int w_cand;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_start = 0;
        w_cand  = 0;

        if (ARB_MODE == ARB_RR) begin
            w_start = (int'(i_rr_ptr) + 1) % NUM_MASTERS;
        end

        // First requester found in search order wins; later hits are masked
        // by o_valid.
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand = (w_start + k) % NUM_MASTERS;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/sys_bus_xbar.sv
// ----------------------------------------------------------------------------
// sys_bus_xbar
// Registered NUM_MASTERS x NUM_SLAVES system bus crossbar with one shared
// transaction channel. A transaction runs IDLE -> BUSY -> RESP (or
// IDLE -> RESP for an unmapped address), so at most one access is in flight.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sys_bus_xbar_if.xbar
//          m_req/m_we/m_adr/m_wdata in, m_rdata/m_ack/m_err/hold_flag out,
//          s_req/s_we/s_adr/s_wdata out, s_rdata/s_ack in
// ----------------------------------------------------------------------------
module sys_bus_xbar
    import sys_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_HI      = 31,
    parameter int SEL_LO      = 28,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int TIMEOUT     = 15
) (
    input  logic         clk,
    input  logic         rst,
    sys_bus_xbar_if.xbar bus
);

    localparam int IDX_W = clog2(NUM_MASTERS);
    localparam int SEL_W = SEL_HI - SEL_LO + 1;
    localparam int CNT_W = clog2(TIMEOUT + 1);

    // Transaction state and latched request
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_g;
    logic [IDX_W-1:0]              r_rr_ptr;
    logic                          r_we;
    logic [ADDR_W-1:0]             r_adr;
    logic [DATA_W-1:0]             r_wdata;
    logic [SEL_W-1:0]              r_sel;
    logic                          r_err_pending;
    logic [CNT_W-1:0]              r_cnt;
    logic [NUM_MASTERS*DATA_W-1:0] r_m_rdata;

    // Arbitration result and the winner's live request fields
    logic [NUM_MASTERS-1:0]        w_grant;
    logic [IDX_W-1:0]              w_grant_idx;
    logic                          w_grant_valid;
    logic                          w_gnt_we;
    logic [ADDR_W-1:0]             w_gnt_adr;
    logic [DATA_W-1:0]             w_gnt_wdata;
    logic [SEL_W-1:0]              w_gnt_sel;
    logic                          w_gnt_mapped;

    // Response from the selected slave
    logic                          w_s_ack;
    logic [DATA_W-1:0]             w_s_rdata;
    logic                          w_timeout;

    sys_bus_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .ARB_MODE    (ARB_MODE)
    ) u_arbiter (
        .i_req    (bus.m_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_grant_idx),
        .o_valid  (w_grant_valid)
    );

    // Mux the winning master's request fields out of the flattened buses.
    always_comb begin
        w_gnt_we    = 1'b0;
        w_gnt_adr   = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant[i]) begin
                w_gnt_we    = bus.m_we[i];
                w_gnt_adr   = bus.m_adr[i*ADDR_W +: ADDR_W];
                w_gnt_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_gnt_sel    = w_gnt_adr[SEL_HI:SEL_LO];
    // Zero-extended compare so any select-field width works against NUM_SLAVES.
    assign w_gnt_mapped = (33'(w_gnt_sel) < 33'(NUM_SLAVES));

    // Only the latched slave's s_ack/s_rdata are observed.
    always_comb begin
        w_s_ack   = 1'b0;
        w_s_rdata = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (33'(r_sel) == 33'(j)) begin
                w_s_ack   = bus.s_ack[j];
                w_s_rdata = bus.s_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = w_gnt_mapped ? BUSY : RESP;
                end
            end
            BUSY: begin
                // s_ack wins over a simultaneous timeout; both end in RESP.
                if (w_s_ack || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, timeout counter, response data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g           <= '0;
            r_rr_ptr      <= IDX_W'(NUM_MASTERS - 1);
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_wdata       <= '0;
            r_sel         <= '0;
            r_err_pending <= 1'b0;
            r_cnt         <= '0;
            r_m_rdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_g           <= w_grant_idx;
                        r_rr_ptr      <= w_grant_idx;
                        r_we          <= w_gnt_we;
                        r_adr         <= w_gnt_adr;
                        r_wdata       <= w_gnt_wdata;
                        r_sel         <= w_gnt_sel;
                        r_err_pending <= !w_gnt_mapped;
                        r_cnt         <= '0;
                        // Unmapped: the error response carries zero data.
                        for (int i = 0; i < NUM_MASTERS; i++) begin
                            if (w_grant[i] && !w_gnt_mapped) begin
                                r_m_rdata[i*DATA_W +: DATA_W] <= '0;
                            end
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (r_g == IDX_W'(i)) begin
                            if (w_s_ack) begin
                                r_m_rdata[i*DATA_W +: DATA_W] <= w_s_rdata;
                            end else if (w_timeout) begin
                                r_m_rdata[i*DATA_W +: DATA_W] <= '0;
                            end
                        end
                    end
                    if (w_s_ack) begin
                        r_err_pending <= 1'b0;
                    end else if (w_timeout) begin
                        r_err_pending <= 1'b1;
                    end
                end
                RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.s_req     = '0;
        bus.m_ack     = '0;
        bus.m_err     = '0;
        // hold_flag is the only output fed straight from an input; force it
        // low during reset so every output reads zero while rst is high.
        bus.hold_flag = rst ? '0 : bus.m_req;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (r_state == BUSY && 33'(r_sel) == 33'(j)) begin
                bus.s_req[j] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_state == RESP && r_g == IDX_W'(i)) begin
                bus.m_ack[i]     = !r_err_pending;
                bus.m_err[i]     = r_err_pending;
                bus.hold_flag[i] = 1'b0;
            end
        end
    end

    assign bus.s_we    = r_we;
    assign bus.s_adr   = r_adr;
    assign bus.s_wdata = r_wdata;
    assign bus.m_rdata = r_m_rdata;

endmodule

// File: tb/tb_sys_bus_xbar.sv
// ----------------------------------------------------------------------------
// tb_sys_bus_xbar
// Two crossbar instances:
//   dut_a : 2 masters, 2 slaves, fixed priority, TIMEOUT=15
//   dut_b : 3 masters, 2 slaves, round-robin,    TIMEOUT=15
// Expected responses (master, ack/err, data, completion cycle) are queued as
// each request is driven and popped when a response pulse appears.
// ----------------------------------------------------------------------------
module tb_sys_bus_xbar;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          b_done = 0;
    int          t;
    logic [1:0]  a_ack_en;
    logic [31:0] a_model [2];
    logic [31:0] b_model [3];
    exp_t        q_a [$];
    exp_t        q_b [$];

    sys_bus_xbar_if #(.NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus_a ();
    sys_bus_xbar_if #(.NUM_MASTERS(3), .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus_b ();

    sys_bus_xbar #(
        .NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32),
        .SEL_HI(31), .SEL_LO(28), .ARB_MODE(sys_bus_pkg::ARB_FIXED), .TIMEOUT(15)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sys_bus_xbar #(
        .NUM_MASTERS(3), .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32),
        .SEL_HI(31), .SEL_LO(28), .ARB_MODE(sys_bus_pkg::ARB_RR), .TIMEOUT(15)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Slave models: combinational (zero-wait) acks, gated per slave on dut_a.
    assign bus_a.s_ack   = bus_a.s_req & a_ack_en;
    assign bus_a.s_rdata = {32'h5555_AAAA, 32'hDEAD_BEEF};
    assign bus_b.s_ack   = bus_b.s_req;
    assign bus_b.s_rdata = {2{bus_b.s_adr ^ 32'hA5A5_0000}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_a(input int m, input logic err, input logic [31:0] rdata, input int c);
        exp_t e;
        e.m = m; e.err = err; e.rdata = rdata; e.cyc = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int m, input logic err, input logic [31:0] rdata, input int c);
        exp_t e;
        e.m = m; e.err = err; e.rdata = rdata; e.cyc = c;
        q_b.push_back(e);
    endtask

    // Advance to the falling edge, score any response pulses, let dut_a
    // masters drop their request on completion, then settle for 1 time unit.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (bus_a.m_ack[i] || bus_a.m_err[i]) begin
                check("a_resp_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check("a_master", i, e.m);
                    check("a_ack", bus_a.m_ack[i], !e.err);
                    check("a_err", bus_a.m_err[i], e.err);
                    check("a_cycle", cyc, e.cyc);
                    a_model[e.m] = e.rdata;
                    for (int j = 0; j < 2; j++)
                        check("a_rdata", bus_a.m_rdata[j*32 +: 32], a_model[j]);
                end
                bus_a.m_req[i] = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (bus_b.m_ack[i] || bus_b.m_err[i]) begin
                check("b_resp_expected", q_b.size() > 0, 1);
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    check("b_master", i, e.m);
                    check("b_ack", bus_b.m_ack[i], !e.err);
                    check("b_cycle", cyc, e.cyc);
                    b_model[e.m] = e.rdata;
                    for (int j = 0; j < 3; j++)
                        check("b_rdata", bus_b.m_rdata[j*32 +: 32], b_model[j]);
                end
                b_done++;
            end
        end
        #1;
    endtask

    // Wait (bounded) for all queued responses, then one more cycle so the
    // crossbar is back in IDLE before the next request is driven.
    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, q_a.size() + q_b.size(), 0);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        a_ack_en      = 2'b11;
        bus_a.m_req   = '0;
        bus_a.m_we    = '0;
        bus_a.m_adr   = '0;
        bus_a.m_wdata = '0;
        bus_b.m_req   = '0;
        bus_b.m_we    = '0;
        bus_b.m_adr   = '0;
        bus_b.m_wdata = '0;
        for (int i = 0; i < 2; i++) a_model[i] = '0;
        for (int i = 0; i < 3; i++) b_model[i] = '0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_s_req", bus_a.s_req, 2'b00);
        check("rst_m_ack", bus_a.m_ack, 2'b00);
        check("rst_m_err", bus_a.m_err, 2'b00);
        check("rst_hold", bus_a.hold_flag, 2'b00);
        check("rst_m_rdata", bus_a.m_rdata, 64'h0);
        check("rst_s_adr", bus_a.s_adr, 32'h0);
        check("rst_b_s_req", bus_b.s_req, 2'b00);
        rst = 1'b0;

        // ---- Fixed priority: both request, master 0 first ----
        bus_a.m_adr = {32'h1000_0000, 32'h0000_0010};
        bus_a.m_we  = 2'b00;
        bus_a.m_req = 2'b11;
        t = cyc;
        push_a(0, 1'b0, 32'hDEAD_BEEF, t + 2);
        push_a(1, 1'b0, 32'h5555_AAAA, t + 5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fix_hold1", bus_a.hold_flag[1], k < 5);
            if (k == 1) check("fix_s_req_m0", bus_a.s_req, 2'b01);
            if (k == 4) check("fix_s_req_m1", bus_a.s_req, 2'b10);
        end
        drain("fix_drain", 10);

        // ---- Unmapped address: error one cycle after sampling ----
        bus_a.m_adr[31:0] = 32'h3000_0000;
        bus_a.m_req       = 2'b01;
        t = cyc;
        push_a(0, 1'b1, 32'h0, t + 1);
        tick();
        check("unmap_no_s_req", bus_a.s_req, 2'b00);
        drain("unmap_drain", 10);

        // ---- Timeout: slave 1 never acks ----
        a_ack_en           = 2'b01;
        bus_a.m_adr[63:32] = 32'h1000_0004;
        bus_a.m_req        = 2'b10;
        t = cyc;
        push_a(1, 1'b1, 32'h0, t + 16);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("tmo_s_req", bus_a.s_req, (k <= 15) ? 2'b10 : 2'b00);
        end
        drain("tmo_drain", 10);

        // ---- Write: master changes its inputs after the grant ----
        bus_a.m_we          = 2'b01;
        bus_a.m_adr[31:0]   = 32'h1000_0008;
        bus_a.m_wdata[31:0] = 32'h1234_5678;
        bus_a.m_req         = 2'b01;
        t = cyc;
        push_a(0, 1'b0, 32'h5555_AAAA, t + 4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("wr_s_req", bus_a.s_req, 2'b10);
            check("wr_s_we", bus_a.s_we, 1'b1);
            check("wr_s_adr", bus_a.s_adr, 32'h1000_0008);
            check("wr_s_wdata", bus_a.s_wdata, 32'h1234_5678);
            if (k == 1) begin
                bus_a.m_wdata[31:0] = 32'hFFFF_0000;
                bus_a.m_adr[31:0]   = 32'h0000_0000;
                bus_a.m_we          = 2'b00;
            end
        end
        a_ack_en = 2'b11;
        drain("wr_drain", 10);

        // ---- Round robin, three masters requesting continuously ----
        bus_b.m_adr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        bus_b.m_req = 3'b111;
        t = cyc;
        for (int k = 0; k < 6; k++)
            push_b(k % 3, 1'b0, (32'h100 * ((k % 3) + 1)) ^ 32'hA5A5_0000, t + 2 + 3 * k);
        b_done = 0;
        for (int n = 0; n < 40 && b_done < 6; n++) tick();
        bus_b.m_req = '0;
        check("rr_six_grants", b_done, 6);
        drain("rr_drain", 10);

        // ---- Reset while BUSY, then re-arbitration ----
        a_ack_en          = 2'b01;
        bus_a.m_adr[31:0] = 32'h1000_0000;
        bus_a.m_req       = 2'b01;
        tick();
        check("rb_busy_s_req", bus_a.s_req, 2'b10);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) a_model[i] = '0;
        tick();
        check("rb_s_req", bus_a.s_req, 2'b00);
        check("rb_m_ack", bus_a.m_ack, 2'b00);
        check("rb_m_err", bus_a.m_err, 2'b00);
        check("rb_hold", bus_a.hold_flag, 2'b00);
        check("rb_m_rdata", bus_a.m_rdata, 64'h0);
        rst      = 1'b0;
        a_ack_en = 2'b11;
        t = cyc;
        push_a(0, 1'b0, 32'h5555_AAAA, t + 2);
        tick();
        check("rb_rearb_s_req", bus_a.s_req, 2'b10);
        drain("rb_drain", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
